// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB first, carry registered between chunks.
// Define SERIAL_ADDSUB_SATURATE_EN to clamp s to the signed limit on overflow.
module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d, s_d;
    logic             op_q, carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_out_q, overflow_q, zero_q, negative_q;
    logic             accept, last;
    logic [CHUNK-1:0] a_k, b_k;
    logic [CHUNK:0]   sum_k;
    logic             msb_cin, ovf_d;
    int               base;

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (cnt_q == CW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Carry into the word MSB is recovered from the top sum bit of the last chunk.
    always_comb begin
        base    = int'(cnt_q) * CHUNK;
        a_k     = a_q[base +: CHUNK];
        b_k     = b_q[base +: CHUNK] ^ {CHUNK{op_q}};
        sum_k   = {1'b0, a_k} + {1'b0, b_k} + (CHUNK + 1)'(carry_q);
        msb_cin = sum_k[CHUNK-1] ^ a_k[CHUNK-1] ^ b_k[CHUNK-1];
        ovf_d   = msb_cin ^ sum_k[CHUNK];
        res_d   = res_q;
        res_d[base +: CHUNK] = sum_k[CHUNK-1:0];
        s_d     = res_d;
`ifdef SERIAL_ADDSUB_SATURATE_EN
        if (ovf_d)
            s_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            s_q         <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= op;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            res_q   <= res_d;
            carry_q <= sum_k[CHUNK];
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                s_q         <= s_d;
                carry_out_q <= sum_k[CHUNK];
                overflow_q  <= ovf_d;
                zero_q      <= (s_d == '0);
                negative_q  <= s_d[WIDTH-1];
            end
        end
    end

    assign s         = s_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four instances (CHUNK 4,1,8,32) checked against a queue of expected results.
module tb_serial_addsub;
    localparam int W  = 32;
    localparam int NI = 4;
`ifdef SERIAL_ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic int chunk_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] s;
        logic         c, v, z, n;
        int           issue;
    } exp_t;

    typedef struct {
        logic         op;
        logic [W-1:0] a, b, s;
        logic         c, v, z, n;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         op;
    logic [W-1:0] a, b;
    logic         start_v  [NI];
    logic         busy_w   [NI];
    logic         done_w   [NI];
    logic [W-1:0] s_w      [NI];
    logic         cout_w   [NI];
    logic         ovf_w    [NI];
    logic         zero_w   [NI];
    logic         neg_w    [NI];

    exp_t exp_q [NI][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int inst, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s inst%0d: got %h expected %h", name, inst, act, req);
        end
    endtask

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            int   busy_cnt = 0;
            exp_t e;

            serial_addsub #(.WIDTH(W), .CHUNK(chunk_of(g))) u_dut (
                .clk(clk), .rst(rst), .start(start_v[g]), .op(op), .a(a), .b(b),
                .busy(busy_w[g]), .done(done_w[g]), .s(s_w[g]), .carry_out(cout_w[g]),
                .overflow(ovf_w[g]), .zero(zero_w[g]), .negative(neg_w[g])
            );

            always @(negedge clk) begin
                if (rst) begin
                    busy_cnt = 0;
                end else begin
                    if (busy_w[g]) busy_cnt++;
                    if (done_w[g]) begin
                        if (exp_q[g].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_done inst%0d: got done=1 expected done=0", g);
                        end else begin
                            e = exp_q[g].pop_front();
                            check("s",         g, s_w[g],    e.s);
                            check("carry_out", g, cout_w[g], W'(e.c));
                            check("overflow",  g, ovf_w[g],  W'(e.v));
                            check("zero",      g, zero_w[g], W'(e.z));
                            check("negative",  g, neg_w[g],  W'(e.n));
                            check("latency",   g, W'(cyc - e.issue), W'(W / chunk_of(g)));
                            check("busy_len",  g, W'(busy_cnt), W'(W / chunk_of(g)));
                            check("done_busy", g, W'(busy_w[g]), '0);
                        end
                        busy_cnt = 0;
                    end
                end
            end
        end
    endgenerate

    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         r;
        logic [W-1:0] yx;
        logic [W:0]   full;
        yx   = o ? ~y : y;
        full = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, o};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.v  = (x[W-1] == yx[W-1]) && (r.s[W-1] != x[W-1]);
        if (SAT && r.v) r.s = x[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.z     = (r.s == '0);
        r.n     = r.s[W-1];
        r.issue = 0;
        return r;
    endfunction

    // Called at a negedge; leaves one negedge later with start released.
    task automatic issue(input logic [NI-1:0] mask, input exp_t e, input logic o,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        op = o;
        a  = x;
        b  = y;
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                start_v[i] = 1'b1;
                e.issue    = cyc + 1;
                exp_q[i].push_back(e);
            end
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            idle = 1'b1;
            for (int i = 0; i < NI; i++)
                if (exp_q[i].size() != 0 || busy_w[i]) idle = 1'b0;
            if (idle) return;
        end
        total++;
        bad++;
        $display("FAIL wait_idle: got no completion within 100 cycles expected completion");
        for (int i = 0; i < NI; i++) exp_q[i].delete();
    endtask

    task automatic wait_done0(input string name);
        for (int t = 0; t < 40 && !done_w[0]; t++) @(negedge clk);
        if (!done_w[0]) begin
            total++;
            bad++;
            $display("FAIL %s: got no done within 40 cycles expected done", name);
        end
    endtask

    vec_t vt [8];
    exp_t e1, e2;
    int   d1;

    initial begin
        vt[0] = '{1'b0, 32'h7FFF_FFFF, 32'h1, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0, !SAT};
        vt[1] = '{1'b1, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 32'h8000_0000, 32'h1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, SAT};
        vt[4] = '{1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, SAT ? 32'h8000_0000 : 32'h1, 1'b1, 1'b1, 1'b0, SAT};
        vt[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, SAT ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1, !SAT, SAT};

        rst = 1'b1;
        op  = 1'b0;
        a   = '0;
        b   = '0;
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_s",     i, s_w[i], '0);
            check("rst_flags", i, W'({busy_w[i], done_w[i], cout_w[i], ovf_w[i], zero_w[i], neg_w[i]}), '0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            e1 = '{vt[k].s, vt[k].c, vt[k].v, vt[k].z, vt[k].n, 0};
            issue('1, e1, vt[k].op, vt[k].a, vt[k].b);
            wait_idle();
        end

        // Back-to-back: start held through RUN and into DONE with a new operand pair.
        e1 = model(1'b0, 32'h0000_1111, 32'h0000_2222);
        e2 = model(1'b1, 32'h0000_0010, 32'h0000_0020);
        op = 1'b0; a = 32'h0000_1111; b = 32'h0000_2222;
        start_v[0] = 1'b1;
        e1.issue = cyc + 1;
        exp_q[0].push_back(e1);
        @(negedge clk);
        op = 1'b1; a = 32'h0000_0010; b = 32'h0000_0020;
        wait_done0("b2b_first_done");
        d1 = cyc;
        e2.issue = cyc + 1;
        exp_q[0].push_back(e2);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_hold_s", 0, s_w[0], e1.s);
        wait_done0("b2b_second_done");
        check("b2b_gap", 0, W'(cyc - d1), W'(W / chunk_of(0) + 1));
        wait_idle();

        // start during RUN cycle 3 must be ignored.
        e1 = model(1'b0, 32'h0F0F_0F0F, 32'h0101_0101);
        issue(4'b0001, e1, 1'b0, 32'h0F0F_0F0F, 32'h0101_0101);
        repeat (2) @(negedge clk);
        op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle();
        repeat (12) @(negedge clk);

        // rst at RUN cycle 5 discards the operation.
        e1 = model(1'b0, 32'h8000_0000, 32'h8000_0001);
        issue(4'b0001, e1, 1'b0, 32'h8000_0000, 32'h8000_0001);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q[0].delete();
        @(negedge clk);
        check("midrst_s",     0, s_w[0], '0);
        check("midrst_flags", 0, W'({busy_w[0], done_w[0], cout_w[0], ovf_w[0], zero_w[0], neg_w[0]}), '0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        e1 = model(1'b1, 32'h0000_0003, 32'h0000_0007);
        issue(4'b0001, e1, 1'b1, 32'h0000_0003, 32'h0000_0007);
        wait_idle();

        for (int k = 0; k < 1000; k++) begin
            logic         o;
            logic [W-1:0] x, y;
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom;
            if ((k % 8) == 0) x = {x[W-1], {(W-1){~x[W-1]}}};
            if ((k % 16) == 4) y = x;
            e1 = model(o, x, y);
            issue('1, e1, o, x, y);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end
endmodule
